// File: rtl/voice_envelope_mixer.sv
// 64-slot time-multiplexed envelope generator and mixer. One voice slot is processed
// per valid cycle, and one saturated mixed sample is emitted per frame (slot 0 to slot 63).
module voice_envelope_mixer #(
    parameter int unsigned ATTACK_STEP  = 8,
    parameter int unsigned RELEASE_STEP = 2,
    parameter int unsigned OUT_SHIFT    = 3
) (
    input  logic       i_clk,
    input  logic       i_res_n,
    input  logic       i_slot_valid,
    input  logic [5:0] i_slot_addr,
    input  logic       i_slot_wave,
    input  logic       i_note_en,
    input  logic [6:0] i_velocity,
    input  logic       i_tick,
    output logic [5:0] o_sound,
    output logic       o_sample_valid
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ATTACK  = 2'd1,
        ST_SUSTAIN = 2'd2,
        ST_RELEASE = 2'd3
    } env_state_e;

    localparam logic [7:0]  ATT_INC   = 8'(ATTACK_STEP);
    localparam logic [7:0]  REL_DEC   = 8'(RELEASE_STEP);
    localparam logic [12:0] SOUND_MAX = 13'd63;

    env_state_e  state_mem_q [64];
    logic [6:0]  level_mem_q [64];

    logic        tick_pending_q, frame_tick_q, frame_started_q;
    logic        s1_valid_q, s1_wave_q, s1_note_on_q, s1_first_q, s1_emit_q;
    logic [5:0]  s1_addr_q;
    logic [6:0]  s1_vel_q, s1_level_q;
    env_state_e  s1_state_q;
    logic [12:0] acc_q, acc_d, acc_shift;
    logic        s2_emit_q, sample_valid_q;
    logic [5:0]  sound_q, sound_d;

    env_state_e  state_d, rd_state;
    logic [6:0]  level_d, rd_level, contrib;
    logic [7:0]  att_sum;
    logic        fwd, slot_first, note_on;

    assign slot_first = i_slot_valid && (i_slot_addr == 6'd0);
    assign note_on    = i_note_en && (i_velocity != 7'd0);

    // Back-to-back visits of one slot must see the write-back still in flight.
    assign fwd      = s1_valid_q && i_slot_valid && (i_slot_addr == s1_addr_q);
    assign rd_state = fwd ? state_d : state_mem_q[i_slot_addr];
    assign rd_level = fwd ? level_d : level_mem_q[i_slot_addr];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = s1_state_q;
        level_d = s1_level_q;
        att_sum = {1'b0, s1_level_q} + ATT_INC;
        unique case (s1_state_q)
            ST_IDLE: begin
                if (s1_note_on_q) state_d = ST_ATTACK;
            end
            ST_ATTACK: begin
                if (!s1_note_on_q) begin
                    state_d = ST_RELEASE;
                end else if (frame_tick_q) begin
                    if (att_sum >= {1'b0, s1_vel_q}) begin
                        level_d = s1_vel_q;
                        state_d = ST_SUSTAIN;
                    end else begin
                        level_d = att_sum[6:0];
                    end
                end
            end
            ST_SUSTAIN: begin
                if (!s1_note_on_q) state_d = ST_RELEASE;
                else               level_d = s1_vel_q;
            end
            ST_RELEASE: begin
                if (s1_note_on_q) begin
                    state_d = ST_ATTACK;
                end else if (frame_tick_q) begin
                    if ({1'b0, s1_level_q} <= REL_DEC) begin
                        level_d = 7'd0;
                        state_d = ST_IDLE;
                    end else begin
                        level_d = s1_level_q - REL_DEC[6:0];
                    end
                end
            end
        endcase
        contrib   = s1_wave_q ? level_d : 7'd0;
        acc_d     = (s1_first_q ? 13'd0 : acc_q) + {6'd0, contrib};
        acc_shift = acc_q >> OUT_SHIFT;
        sound_d   = (acc_shift > SOUND_MAX) ? 6'd63 : acc_shift[5:0];
    end

    // NOTE: the slot storage sits in the async-reset domain because every voice must
    // come out of reset IDLE at level 0, so it maps to flops rather than a RAM macro.
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            for (int i = 0; i < 64; i++) begin
                state_mem_q[i] <= ST_IDLE;
                level_mem_q[i] <= 7'd0;
            end
            tick_pending_q  <= 1'b0;
            frame_tick_q    <= 1'b0;
            frame_started_q <= 1'b0;
            s1_valid_q      <= 1'b0;
            s1_wave_q       <= 1'b0;
            s1_note_on_q    <= 1'b0;
            s1_first_q      <= 1'b0;
            s1_emit_q       <= 1'b0;
            s1_addr_q       <= 6'd0;
            s1_vel_q        <= 7'd0;
            s1_level_q      <= 7'd0;
            s1_state_q      <= ST_IDLE;
            acc_q           <= 13'd0;
            s2_emit_q       <= 1'b0;
            sample_valid_q  <= 1'b0;
            sound_q         <= 6'd0;
        end else begin
            if (slot_first) begin
                frame_tick_q    <= tick_pending_q | i_tick;
                tick_pending_q  <= 1'b0;
                frame_started_q <= 1'b1;
            end else if (i_tick) begin
                tick_pending_q  <= 1'b1;
            end

            s1_valid_q <= i_slot_valid;
            if (i_slot_valid) begin
                s1_addr_q    <= i_slot_addr;
                s1_wave_q    <= i_slot_wave;
                s1_note_on_q <= note_on;
                s1_vel_q     <= i_velocity;
                s1_state_q   <= rd_state;
                s1_level_q   <= rd_level;
                s1_first_q   <= slot_first;
                s1_emit_q    <= (i_slot_addr == 6'd63) && frame_started_q;
                if (i_slot_addr == 6'd63) frame_started_q <= 1'b0;
            end

            if (s1_valid_q) begin
                state_mem_q[s1_addr_q] <= state_d;
                level_mem_q[s1_addr_q] <= level_d;
                acc_q                  <= acc_d;
            end

            s2_emit_q      <= s1_valid_q && s1_emit_q;
            sample_valid_q <= s2_emit_q;
            if (s2_emit_q) sound_q <= sound_d;
        end
    end

    assign o_sound        = sound_q;
    assign o_sample_valid = sample_valid_q;

endmodule

// File: tb/tb_voice_envelope_mixer.sv
// Directed bench for voice_envelope_mixer: each frame pushes its hand-derived sample
// into a queue, and an independent monitor pops it whenever o_sample_valid pulses.
module tb_voice_envelope_mixer;

    localparam logic [63:0] FULL = '1;

    logic       i_clk = 1'b0;
    logic       i_res_n = 1'b0;
    logic       i_slot_valid = 1'b0;
    logic [5:0] i_slot_addr = 6'd0;
    logic       i_slot_wave = 1'b0;
    logic       i_note_en = 1'b0;
    logic [6:0] i_velocity = 7'd0;
    logic       i_tick = 1'b0;
    logic [5:0] o_sound;
    logic       o_sample_valid;

    always #5 i_clk = ~i_clk;

    voice_envelope_mixer dut (
        .i_clk          (i_clk),
        .i_res_n        (i_res_n),
        .i_slot_valid   (i_slot_valid),
        .i_slot_addr    (i_slot_addr),
        .i_slot_wave    (i_slot_wave),
        .i_note_en      (i_note_en),
        .i_velocity     (i_velocity),
        .i_tick         (i_tick),
        .o_sound        (o_sound),
        .o_sample_valid (o_sample_valid)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned frame_idx = 0;
    int          exp_q[$];

    logic       cfg_note [64];
    logic [6:0] cfg_vel  [64];
    logic       cfg_wave [64];
    bit         dup_en = 1'b0;
    logic       dup_note = 1'b0;
    logic [6:0] dup_vel = 7'd0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: every emitted sample is matched against the oldest outstanding expectation.
    always @(negedge i_clk) begin
        if (i_res_n && o_sample_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_sample", o_sample_valid, 0);
            end else begin
                frame_idx++;
                check($sformatf("frame%0d_sound", frame_idx), o_sound, exp_q.pop_front());
            end
        end
    end

    task automatic expect_sound(input int v);
        exp_q.push_back(v);
    endtask

    task automatic set_slots(input int lo, input int hi, input logic n, input logic [6:0] v, input logic w);
        for (int s = lo; s <= hi; s++) begin
            cfg_note[s] = n;
            cfg_vel[s]  = v;
            cfg_wave[s] = w;
        end
    endtask

    task automatic drive(input logic v, input logic [5:0] a, input logic w, input logic n,
                         input logic [6:0] vel, input logic t);
        @(posedge i_clk);
        #1;
        i_slot_valid = v;
        i_slot_addr  = a;
        i_slot_wave  = w;
        i_note_en    = n;
        i_velocity   = vel;
        i_tick       = t;
    endtask

    task automatic present(input int s, input logic t);
        drive(1'b1, 6'(s), cfg_wave[s], cfg_note[s], cfg_vel[s], t);
    endtask

    // gap_ticks: separate pulses before slot 0; slot0_tick: pulse alongside slot 0;
    // mid_tick: pulse at slot 20, which belongs to the following frame.
    task automatic run_frame(input int gap_ticks, input bit slot0_tick, input bit mid_tick,
                             input logic [63:0] mask);
        logic tk;
        for (int g = 0; g < 6; g++)
            drive(1'b0, 6'd0, 1'b0, 1'b0, 7'd0, (g % 2 == 0) && (g / 2 < gap_ticks));
        for (int s = 0; s < 64; s++) begin
            tk = (s == 0 && slot0_tick) || (s == 20 && mid_tick);
            if (mask[s]) begin
                if (s == 5 && dup_en) drive(1'b1, 6'd5, cfg_wave[5], dup_note, dup_vel, 1'b0);
                present(s, tk);
            end else begin
                drive(1'b0, 6'(s), 1'b0, 1'b0, 7'd0, tk);
            end
        end
        drive(1'b0, 6'd0, 1'b0, 1'b0, 7'd0, 1'b0);
        drive(1'b0, 6'd0, 1'b0, 1'b0, 7'd0, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [63:0] m;
        int lvl;

        set_slots(0, 63, 1'b0, 7'd0, 1'b0);
        repeat (3) @(posedge i_clk);
        #1;
        check("reset_sound", o_sound, 0);
        check("reset_valid", o_sample_valid, 0);
        @(negedge i_clk);
        i_res_n = 1'b1;

        // Attack of slot 5, tick collapse, tick timing variants
        set_slots(5, 5, 1'b1, 7'd100, 1'b1);
        expect_sound(0);  run_frame(0, 0, 0, FULL);
        expect_sound(1);  run_frame(3, 0, 0, FULL);
        expect_sound(1);  run_frame(0, 0, 0, FULL);
        expect_sound(2);  run_frame(0, 1, 0, FULL);
        expect_sound(2);  run_frame(0, 0, 1, FULL);
        expect_sound(3);  run_frame(0, 0, 0, FULL);
        for (int k = 4; k <= 12; k++) begin
            expect_sound(k); run_frame(1, 0, 0, FULL);
        end
        expect_sound(12); run_frame(1, 0, 0, FULL);
        expect_sound(12); run_frame(1, 0, 0, FULL);

        // Back-to-back visits of slot 5: note-off then note-on leaves it in ATTACK at 100
        dup_en = 1'b1; dup_note = 1'b0; dup_vel = 7'd100;
        expect_sound(25); run_frame(0, 0, 0, FULL);
        dup_en = 1'b0;
        set_slots(5, 5, 1'b1, 7'd50, 1'b1);
        expect_sound(12); run_frame(0, 0, 0, FULL);
        expect_sound(6);  run_frame(1, 0, 0, FULL);
        set_slots(5, 5, 1'b1, 7'd100, 1'b1);
        expect_sound(12); run_frame(0, 0, 0, FULL);

        // Skipped slots
        m = '0; m[0] = 1'b1; m[5] = 1'b1; m[63] = 1'b1;
        expect_sound(12); run_frame(0, 0, 0, m);
        m = FULL; m[5] = 1'b0;
        expect_sound(0);  run_frame(0, 0, 0, m);
        expect_sound(12); run_frame(0, 0, 0, FULL);

        // Release and retrigger
        set_slots(5, 5, 1'b0, 7'd100, 1'b1);
        expect_sound(12); run_frame(0, 0, 0, FULL);
        for (int r = 1; r <= 20; r++) begin
            expect_sound((100 - 2 * r) >> 3); run_frame(1, 0, 0, FULL);
        end
        set_slots(5, 5, 1'b1, 7'd100, 1'b1);
        expect_sound(7);  run_frame(0, 0, 0, FULL);
        for (int a = 1; a <= 5; a++) begin
            expect_sound((60 + 8 * a) >> 3); run_frame(1, 0, 0, FULL);
        end
        expect_sound(12); run_frame(1, 0, 0, FULL);

        // Eight equal voices: o_sound equals the common level, saturating at 63
        set_slots(5, 5, 1'b0, 7'd0, 1'b0);
        set_slots(8, 15, 1'b1, 7'd127, 1'b1);
        expect_sound(0);  run_frame(0, 0, 0, FULL);
        for (int a = 1; a <= 16; a++) begin
            expect_sound((8 * a > 63) ? 63 : 8 * a); run_frame(1, 0, 0, FULL);
        end
        expect_sound(63); run_frame(1, 0, 0, FULL);

        // Velocity-0 note-on releases; idle slots with wave=1 add nothing
        set_slots(8, 15, 1'b1, 7'd0, 1'b1);
        set_slots(0, 4, 1'b0, 7'd0, 1'b1);
        set_slots(6, 7, 1'b0, 7'd0, 1'b1);
        set_slots(16, 63, 1'b0, 7'd0, 1'b1);
        expect_sound(63); run_frame(0, 0, 0, FULL);
        for (int r = 1; r <= 64; r++) begin
            lvl = 127 - 2 * r;
            if (lvl < 0) lvl = 0;
            expect_sound((lvl > 63) ? 63 : lvl); run_frame(1, 0, 0, FULL);
        end
        expect_sound(0);  run_frame(1, 0, 0, FULL);
        set_slots(8, 15, 1'b1, 7'd127, 1'b1);
        expect_sound(0);  run_frame(0, 0, 0, FULL);
        expect_sound(8);  run_frame(1, 0, 0, FULL);
        expect_sound(16); run_frame(1, 0, 0, FULL);

        // Reset in the middle of a frame
        for (int s = 0; s <= 30; s++) present(s, 1'b0);
        drive(1'b0, 6'd0, 1'b0, 1'b0, 7'd0, 1'b0);
        check("pre_reset_sound", o_sound, 16);
        #2;
        i_res_n = 1'b0;
        #1;
        check("mid_reset_sound", o_sound, 0);
        check("mid_reset_valid", o_sample_valid, 0);
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_res_n = 1'b1;
        for (int s = 31; s <= 63; s++) present(s, 1'b0);
        repeat (6) drive(1'b0, 6'd0, 1'b0, 1'b0, 7'd0, 1'b0);
        expect_sound(0);  run_frame(0, 0, 0, FULL);
        expect_sound(8);  run_frame(1, 0, 0, FULL);

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(posedge i_clk);
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/voice_envelope_mixer.md
VOICE_ENVELOPE_MIXER -- requirements
Module: voice_envelope_mixer

Interface
REQ-001 SHALL provide parameter ATTACK_STEP, default 8, envelope level increment per tick frame during attack.
REQ-002 SHALL provide parameter RELEASE_STEP, default 2, envelope level decrement per tick frame during release.
REQ-003 SHALL provide parameter OUT_SHIFT, default 3, right shift applied to the frame sum before saturation.
REQ-004 SHALL have port i_clk  input  1  single clock for all logic.
REQ-005 SHALL have port i_res_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_slot_valid  input  1  slot data below valid this cycle.
REQ-007 SHALL have port i_slot_addr  input  6  voice slot index 0-63.
REQ-008 SHALL have port i_slot_wave  input  1  current square-wave level of this slot (DDS phase MSB).
REQ-009 SHALL have port i_note_en  input  1  note-on flag of this slot.
REQ-010 SHALL have port i_velocity  input  7  note velocity of this slot.
REQ-011 SHALL have port i_tick  input  1  envelope step strobe, one cycle wide.
REQ-012 SHALL have port o_sound  output  6  mixed sample to the delta-sigma DAC.
REQ-013 SHALL have port o_sample_valid  output  1  one-cycle pulse when o_sound updates.

Function
REQ-014 SHALL hold per slot a 2-bit state (IDLE, ATTACK, SUSTAIN, RELEASE) and 7-bit level in 64-entry storage, read/updated only when that slot is presented.
REQ-015 SHALL process a valid slot in a 2-stage pipeline: stage 1 registers inputs and reads storage, stage 2 writes back state/level and accumulates.
REQ-016 SHALL forward stage-2 write-back to stage 1 when the same address is presented on consecutive valid cycles.
REQ-017 SHALL treat i_note_en=1 with i_velocity=0 as note-off.
REQ-018 SHALL transition IDLE->ATTACK on note-on, level unchanged (0).
REQ-019 SHALL transition ATTACK/SUSTAIN->RELEASE on note-off, on any visit.
REQ-020 SHALL transition RELEASE->ATTACK on note-on, level continuing from current value (retrigger, no reset to 0).
REQ-021 SHALL, in ATTACK on a tick frame, add ATTACK_STEP; result >= i_velocity sets level=i_velocity and state SUSTAIN.
REQ-022 SHALL, in SUSTAIN, set level=i_velocity on every visit (velocity tracking, no tick needed).
REQ-023 SHALL, in RELEASE on a tick frame, subtract RELEASE_STEP; result <= 0 sets level=0 and state IDLE.
REQ-024 SHALL change levels only on tick frames; state transitions of REQ-018..020 occur on every visit.
REQ-025 SHALL latch i_tick into tick_pending; on a valid slot 0, frame_tick <= tick_pending|i_tick and tick_pending cleared; multiple ticks between frames collapse to one.
REQ-026 SHALL, on valid slot 0, clear the 13-bit accumulator before adding slot 0's contribution.
REQ-027 SHALL add the post-update level of a slot to the accumulator when i_slot_wave=1, else add 0.
REQ-028 SHALL, 2 cycles after valid slot 63 enters, set o_sound=min(acc>>OUT_SHIFT, 63) and pulse o_sample_valid for 1 cycle.
REQ-029 SHALL still emit at slot 63 if intermediate slots were skipped; missing slots contribute 0 and keep stored state.
REQ-030 SHALL hold o_sound between emissions; cycles with i_slot_valid=0 have no effect except tick latching.

Reset
REQ-031 SHALL on i_res_n=0 asynchronously clear all states to IDLE, levels to 0, accumulator, tick_pending, frame_tick, pipeline valids, o_sound=0, o_sample_valid=0.
REQ-032 SHALL clear a frame_started flag on reset and emit no o_sample_valid until a valid slot 0 has been seen; reset mid-frame aborts that frame.

Verification
REQ-033 Attack: slot 5 note_en=1 vel=100, wave=1, tick every frame -> level 8,16,...,96, then 100 SUSTAIN; o_sound=min(100>>3,63)=12 thereafter.
REQ-034 Release/retrigger: slot 5 at 100 gets note_en=0 -> decreases 2/tick frame; note_en=1 at level 60 -> ATTACK from 60, reaches 100 after 5 tick frames.
REQ-035 Saturation: 8 slots SUSTAIN vel=127, wave=1 -> sum 1016, >>3=127 -> o_sound=63.
REQ-036 Tick collapse: 3 i_tick pulses within one frame -> levels advance exactly one step next frame; no tick -> levels constant.
REQ-037 Velocity-0 note-on in SUSTAIN -> RELEASE; IDLE with wave=1 contributes 0, o_sound=0.
REQ-038 Reset asserted at slot 30 -> outputs 0 immediately; slots 31-63 after release produce no o_sample_valid; next complete frame emits.
